sap_datapath: RTL
=================

Name: sap_datapath

Overview:
- Datapath that consumes the 15-bit control word from the SAP-style controller and returns the instruction opcode to it.
- Contains PC, MAR, 16x8 RAM, IR, accumulator A, register B, adder/subtractor, output register and a single shared 8-bit bus.
- All state updates on posedge clk. The controller changes its control word on negedge, so the word is stable at each posedge.

Parameters:
- DATA_W, 8, bus/register/RAM word width; must equal ADDR_W+4.
- ADDR_W, 4, PC/MAR/operand width; RAM depth 2**ADDR_W.

Ports:
- clk  in  1  system clock, posedge active.
- rst  in  1  reset, asynchronous, active-high.
- ctrl  in  15  control word; bit order is listed under Behaviour.
- opcode  out  4  IR[DATA_W-1:ADDR_W], to controller.
- prog_we  in  1  external RAM write strobe (program load).
- prog_addr  in  ADDR_W  external write address.
- prog_data  in  DATA_W  external write data.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse after the output register loads.
- halted  out  1  sticky halt flag.
- carry  out  1  adder carry flag.
- zero  out  1  adder zero flag.
- bus_conflict  out  1  sticky error flag; set if more than one bus driver is active.
- bus_dbg  out  DATA_W  current bus value.

Behaviour:
- ctrl bit map:
  - [14] hlt, [13] pc_inc, [12] pc_load, [11] pc_en, [10] mar_load
  - [9] mem_st, [8] mem_en, [7] ir_load, [6] ir_en, [5] a_load
  - [4] a_en, [3] b_load, [2] adder_sub, [1] adder_en, [0] out_load
- Bus drivers (combinational):
  - pc_en drives PC, zero-extended.
  - mem_en drives RAM[MAR].
  - ir_en drives IR[ADDR_W-1:0], zero-extended.
  - a_en drives A.
  - adder_en drives the adder result.
  - No driver active: bus = 0.
  - More than one driver: priority adder_en > mem_en > a_en > ir_en > pc_en, and bus_conflict is set (sticky until rst).
- Adder (combinational):
  - adder_sub=0: sum = A + B.
  - adder_sub=1: sum = A + ~B + 1.
  - Computed at DATA_W+1 bits; result = low DATA_W bits (wraps).
  - cout = bit DATA_W. For subtract, cout=1 means no borrow.
- Posedge updates, all in the same cycle, all from the same bus value:
  - pc_load: PC <= bus[ADDR_W-1:0].
  - pc_inc: PC <= PC+1, wrapping 15 -> 0. pc_load wins if both are asserted.
  - mar_load: MAR <= bus[ADDR_W-1:0].
  - mem_st: RAM[MAR] <= bus.
  - prog_we: RAM[prog_addr] <= prog_data. If mem_st targets the same address in the same cycle, prog_we wins.
  - ir_load: IR <= bus.
  - a_load: A <= bus.
  - b_load: B <= bus.
  - out_load: out_data <= bus; out_valid = 1 for the next cycle only.
  - a_load && adder_en: carry <= cout, zero <= (result==0). Flags hold otherwise.
  - hlt: halted <= 1.
- Halt:
  - Once halted=1, every ctrl bit is ignored; all registers and flags freeze.
  - out_valid = 0 while halted.
  - prog_we still works.
  - Only rst clears halted.
  - The hlt cycle itself performs no other update.
- Reset:
  - Async; clears PC, MAR, IR, A, B, out_data, out_valid, halted, carry, zero, bus_conflict.
  - Reset mid-instruction aborts it immediately.
  - RAM is not cleared.
- Derived outputs:
  - opcode = IR[DATA_W-1:ADDR_W]; reset value 0 (NOP).
  - bus_dbg = bus.
- Combinational latency: bus to register input is zero cycles; register output is visible on the bus the cycle after load.
- No combinational path from any output back to ctrl.

Test Plan:
- Reset/idle: rst mid-run, then ctrl=0 for 3 cycles -> PC=0, A=0, opcode=0, out_data=0, all flags 0, bus_dbg=0.
- Program run with controller model:
  - Load RAM: 0x1E LDA 14, 0x2F ADD 15, 0xE0 OUT, 0xF0 HLT; RAM[14]=28, RAM[15]=14.
  - Release rst -> out_data=42 with a single out_valid pulse, then halted=1, PC=4.
  - A=42 held for 20 further cycles.
- Subtract/flags: A=5, B=5, SUB sequence (adder_sub|adder_en|a_load) -> A=0, zero=1, carry=1. Then A=3, B=5 -> A=0xFE, zero=0, carry=0.
- Store/jump: A=0x77, STA 13 -> RAM[13]=0x77. Then JMP 9 (ir_en|pc_load) with IR=0x59 -> PC=9. pc_inc at PC=15 -> PC=0.
- Bus conflict: ctrl with pc_en and mem_en together, mar_load set -> MAR=RAM[MAR][3:0], bus_conflict=1 and remains 1 after ctrl returns to 0.
- Halt freeze and prog collision:
  - After HLT, drive a_load|mem_en -> A unchanged; prog_we to addr 3 with 0xAB -> RAM[3]=0xAB.
  - Same-cycle mem_st and prog_we to the same address -> prog_data is stored.

Source files
------------

// File: rtl/sap_datapath.sv
// SAP-style datapath: PC, MAR, 16x8 RAM, IR, A, B, adder/subtractor and output register
// around one shared bus. The controller supplies the 15-bit control word and reads back the opcode.
module sap_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [14:0]       ctrl,
    output logic [3:0]        opcode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              carry,
    output logic              zero,
    output logic              bus_conflict,
    output logic [DATA_W-1:0] bus_dbg
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Field order matches the control word, MSB first.
    typedef struct packed {
        logic hlt;
        logic pc_inc;
        logic pc_load;
        logic pc_en;
        logic mar_load;
        logic mem_st;
        logic mem_en;
        logic ir_load;
        logic ir_en;
        logic a_load;
        logic a_en;
        logic b_load;
        logic adder_sub;
        logic adder_en;
        logic out_load;
    } ctrl_t;

    ctrl_t             c_act;
    logic              upd;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] ram [DEPTH];

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] adder_res;
    logic              adder_cout;
    logic [4:0]        drv_vec;
    logic              conflict;

    // A halted machine ignores the whole control word, bus drivers included.
    assign c_act = halted ? ctrl_t'('0) : ctrl_t'(ctrl);
    // The hlt cycle itself commits nothing except the halt flag.
    assign upd   = !halted && !c_act.hlt;

    assign mem_rd = ram[mar];

    assign sum        = {1'b0, a_reg}
                      + {1'b0, (c_act.adder_sub ? ~b_reg : b_reg)}
                      + {{DATA_W{1'b0}}, c_act.adder_sub};
    assign adder_res  = sum[DATA_W-1:0];
    assign adder_cout = sum[DATA_W];

    // More than one set bit means two drivers are fighting for the bus.
    assign drv_vec  = {c_act.adder_en, c_act.mem_en, c_act.a_en, c_act.ir_en, c_act.pc_en};
    assign conflict = |(drv_vec & (drv_vec - 5'd1));

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        bus = '0;
        if (c_act.adder_en)
            bus = adder_res;
        else if (c_act.mem_en)
            bus = mem_rd;
        else if (c_act.a_en)
            bus = a_reg;
        else if (c_act.ir_en)
            bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
        else if (c_act.pc_en)
            bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same bus value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= '0;
            mar <= '0;
            ir  <= '0;
        end else if (upd) begin
            if (c_act.pc_load)
                pc <= bus[ADDR_W-1:0];
            else if (c_act.pc_inc)
                pc <= pc + 1'b1;
            if (c_act.mar_load)
                mar <= bus[ADDR_W-1:0];
            if (c_act.ir_load)
                ir <= bus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (upd) begin
            if (c_act.a_load)
                a_reg <= bus;
            if (c_act.b_load)
                b_reg <= bus;
            if (c_act.a_load && c_act.adder_en) begin
                carry <= adder_cout;
                zero  <= (adder_res == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data     <= '0;
            out_valid    <= 1'b0;
            halted       <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            out_valid <= upd && c_act.out_load;
            if (upd && c_act.out_load)
                out_data <= bus;
            if (upd && conflict)
                bus_conflict <= 1'b1;
            if (c_act.hlt)
                halted <= 1'b1;
        end
    end

    // NOTE: the RAM has no reset so the loaded program survives rst and maps onto plain memory.
    always_ff @(posedge clk) begin
        if (upd && c_act.mem_st && !(prog_we && (prog_addr == mar)))
            ram[mar] <= bus;
        if (prog_we)
            ram[prog_addr] <= prog_data;
    end

    assign opcode  = ir[DATA_W-1:ADDR_W];
    assign bus_dbg = bus;

endmodule
